// File: rtl/native_to_axis.sv
// Native (free-running) video to AXI4-Stream video bridge with frame lock, a one-pixel
// hold stage that finds end-of-line, and an output FIFO with a sticky overflow flag.
module native_to_axis #(
    parameter int unsigned DATA_WID   = 24,
    parameter int unsigned PPL_WID    = 12,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [DATA_WID-1:0] vid_data,
    input  logic                vid_vsync,
    input  logic                vid_active,
    output logic                vid_vtg_ce,
    output logic [DATA_WID-1:0] m_tdata,
    output logic                m_tuser,
    output logic                m_tlast,
    output logic                m_tvalid,
    input  logic                m_tready,
    input  logic                ovf_clr,
    output logic                ovf,
    output logic [PPL_WID-1:0]  line_len
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned EW = DATA_WID + 2;

    typedef enum logic [1:0] {
        StWaitVs,
        StArm,
        StRun
    } state_e;

    state_e              state_q;
    logic                vsync_q;
    logic                hold_valid_q;
    logic                hold_sof_q;
    logic [DATA_WID-1:0] hold_data_q;

    logic [EW-1:0]       mem_q [FIFO_DEPTH];
    logic [AW-1:0]       wptr_q;
    logic [AW-1:0]       rptr_q;
    logic [AW:0]         count_q;
    logic [AW:0]         count_d;

    logic                tvalid_q;
    logic                tuser_q;
    logic                tlast_q;
    logic [DATA_WID-1:0] tdata_q;

    logic                ovf_q;
    logic [PPL_WID-1:0]  pix_cnt_q;
    logic [PPL_WID-1:0]  pix_cnt_inc;
    logic [PPL_WID-1:0]  line_len_q;
    logic                vtg_ce_q;

    logic                vs_rise;
    logic                pop;
    logic                full;
    logic                wr_req;
    logic                wr_last;
    logic                overflow;
    logic                wr_en;
    logic                head_avail;
    logic [AW-1:0]       rd_idx;

    // ------------------------------------------------------------------
    // Write decision: in RUN the held pixel leaves when a new pixel replaces it
    // (line continues), or when active drops or vsync rises (line ends).
    // ------------------------------------------------------------------
    always_comb begin
        vs_rise  = vid_vsync & ~vsync_q;
        pop      = tvalid_q & m_tready;
        full     = (count_q == (AW+1)'(FIFO_DEPTH));
        wr_req   = (state_q == StRun) & hold_valid_q;
        wr_last  = vs_rise | ~vid_active;
        overflow = wr_req & full & ~pop;
        wr_en    = wr_req & ~overflow;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StWaitVs;
            vsync_q      <= 1'b0;
            hold_valid_q <= 1'b0;
            hold_sof_q   <= 1'b0;
            hold_data_q  <= '0;
        end else begin
            vsync_q <= vid_vsync;
            if (overflow) begin
                state_q      <= StWaitVs;
                hold_valid_q <= 1'b0;
            end else begin
                case (state_q)
                    StWaitVs: begin
                        if (vs_rise) begin
                            state_q <= StArm;
                        end
                    end
                    StArm: begin
                        if (vid_active) begin
                            state_q      <= StRun;
                            hold_valid_q <= 1'b1;
                            hold_sof_q   <= 1'b1;
                            hold_data_q  <= vid_data;
                        end
                    end
                    StRun: begin
                        // A pixel coinciding with the vsync edge belongs to no frame.
                        if (vs_rise) begin
                            state_q      <= StArm;
                            hold_valid_q <= 1'b0;
                        end else if (vid_active) begin
                            hold_valid_q <= 1'b1;
                            hold_sof_q   <= 1'b0;
                            hold_data_q  <= vid_data;
                        end else begin
                            hold_valid_q <= 1'b0;
                        end
                    end
                    default: begin
                        state_q      <= StWaitVs;
                        hold_valid_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    // ------------------------------------------------------------------
    // Output FIFO. count_q includes the entry on m_t*, so capacity is exactly
    // FIFO_DEPTH; the head register only sees entries written on earlier edges.
    // ------------------------------------------------------------------
    always_comb begin
        head_avail = pop ? (count_q > (AW+1)'(1)) : (count_q != '0);
        rd_idx     = pop ? (rptr_q + AW'(1)) : rptr_q;
        count_d    = count_q;
        if (wr_en && !pop) begin
            count_d = count_q + (AW+1)'(1);
        end else if (!wr_en && pop) begin
            count_d = count_q - (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wptr_q] <= {hold_sof_q, wr_last, hold_data_q};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q   <= '0;
            rptr_q   <= '0;
            count_q  <= '0;
            tvalid_q <= 1'b0;
            tuser_q  <= 1'b0;
            tlast_q  <= 1'b0;
            tdata_q  <= '0;
        end else begin
            if (wr_en) begin
                wptr_q <= wptr_q + AW'(1);
            end
            if (pop) begin
                rptr_q <= rptr_q + AW'(1);
            end
            count_q  <= count_d;
            tvalid_q <= head_avail;
            if (head_avail) begin
                {tuser_q, tlast_q, tdata_q} <= mem_q[rd_idx];
            end else begin
                {tuser_q, tlast_q, tdata_q} <= '0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Line length, sticky overflow and timing-generator enable.
    // ------------------------------------------------------------------
    assign pix_cnt_inc = (&pix_cnt_q) ? pix_cnt_q : pix_cnt_q + PPL_WID'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            pix_cnt_q  <= '0;
            line_len_q <= '0;
            ovf_q      <= 1'b0;
            vtg_ce_q   <= 1'b0;
        end else begin
            vtg_ce_q <= 1'b1;
            if (overflow) begin
                ovf_q <= 1'b1;
            end else if (ovf_clr) begin
                ovf_q <= 1'b0;
            end
            if (overflow) begin
                pix_cnt_q <= '0;
            end else if (wr_en) begin
                if (wr_last) begin
                    line_len_q <= pix_cnt_inc;
                    pix_cnt_q  <= '0;
                end else begin
                    pix_cnt_q <= pix_cnt_inc;
                end
            end
        end
    end

    assign vid_vtg_ce = vtg_ce_q;
    assign m_tvalid   = tvalid_q;
    assign m_tuser    = tuser_q;
    assign m_tlast    = tlast_q;
    assign m_tdata    = tdata_q;
    assign ovf        = ovf_q;
    assign line_len   = line_len_q;

endmodule

// File: tb/tb_native_to_axis.sv
// Scoreboard bench for native_to_axis: a frame/line-level model pushes expected beats,
// a negedge monitor pops and compares every transferred beat.
module tb_native_to_axis;

    localparam int DW = 24;
    localparam int PW = 12;

    typedef struct packed {
        logic          user;
        logic          last;
        logic [DW-1:0] data;
    } beat_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [DW-1:0] vid_data = '0;
    logic          vid_vsync = 1'b0;
    logic          vid_active = 1'b0;
    logic          vid_vtg_ce;
    logic [DW-1:0] m_tdata;
    logic          m_tuser;
    logic          m_tlast;
    logic          m_tvalid;
    logic          m_tready = 1'b1;
    logic          ovf_clr = 1'b0;
    logic          ovf;
    logic [PW-1:0] line_len;

    native_to_axis #(
        .DATA_WID  (DW),
        .PPL_WID   (PW),
        .FIFO_DEPTH(16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .vid_data  (vid_data),
        .vid_vsync (vid_vsync),
        .vid_active(vid_active),
        .vid_vtg_ce(vid_vtg_ce),
        .m_tdata   (m_tdata),
        .m_tuser   (m_tuser),
        .m_tlast   (m_tlast),
        .m_tvalid  (m_tvalid),
        .m_tready  (m_tready),
        .ovf_clr   (ovf_clr),
        .ovf       (ovf),
        .line_len  (line_len)
    );

    always #5 clk = ~clk;

    int    n_cmp = 0;
    int    n_fail = 0;
    int    cycle = 0;
    int    ready_low_until = 0;
    bit    rand_ready = 0;
    bit    locked = 0;
    bit    sof_pending = 0;
    int    exp_len = 0;
    beat_t q[$];

    // Monitor: a beat transfers on the posedge following a negedge with valid & ready.
    bit    stall_prev = 0;
    beat_t prev_beat;
    int    beat_no = 0;
    always @(negedge clk) begin
        beat_t got;
        beat_t exp;
        got = {m_tuser, m_tlast, m_tdata};
        if (rst) begin
            stall_prev = 0;
        end else begin
            if (stall_prev) begin
                n_cmp++;
                if (m_tvalid !== 1'b1 || got !== prev_beat) begin
                    n_fail++;
                    $display("FAIL stall_hold: got valid=%0b %07h required valid=1 %07h",
                             m_tvalid, got, prev_beat);
                end
            end
            if (m_tvalid === 1'b1 && m_tready === 1'b1) begin
                n_cmp++;
                if (q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_beat: got user=%0b last=%0b data=%06h required none",
                             m_tuser, m_tlast, m_tdata);
                end else begin
                    exp = q.pop_front();
                    if (got !== exp) begin
                        n_fail++;
                        $display("FAIL beat%0d: got user=%0b last=%0b data=%06h required user=%0b last=%0b data=%06h",
                                 beat_no, got.user, got.last, got.data, exp.user, exp.last, exp.data);
                    end
                end
                beat_no++;
            end
            stall_prev = (m_tvalid === 1'b1) && (m_tready === 1'b0);
            prev_beat  = got;
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h", name, got, exp);
        end
    endtask

    task automatic cyc(input logic vs, input logic act, input logic [DW-1:0] d);
        vid_vsync  = vs;
        vid_active = act;
        vid_data   = act ? d : '0;
        if (cycle < ready_low_until) m_tready = 1'b0;
        else if (rand_ready)         m_tready = ($urandom_range(0, 3) != 0);
        else                         m_tready = 1'b1;
        @(posedge clk);
        #1;
        cycle++;
    endtask

    // One line of n active pixels (base < 0 -> random data), then gap idle cycles.
    task automatic line(input int n, input int gap, input int base);
        logic [DW-1:0] d;
        beat_t b;
        for (int i = 0; i < n; i++) begin
            d = (base >= 0) ? DW'(base + i) : DW'($urandom);
            if (locked) begin
                b.user = sof_pending;
                b.last = (i == n - 1);
                b.data = d;
                q.push_back(b);
                sof_pending = 0;
            end
            cyc(1'b0, 1'b1, d);
        end
        if (locked && n > 0) exp_len = n;
        for (int i = 0; i < gap; i++) cyc(1'b0, 1'b0, '0);
    endtask

    task automatic vsync_pulse(input int w);
        for (int i = 0; i < w; i++) cyc(1'b1, 1'b0, '0);
        cyc(1'b0, 1'b0, '0);
        locked = 1;
        sof_pending = 1;
    endtask

    task automatic wait_drain();
        int t = 0;
        while (q.size() != 0 && t < 300) begin
            cyc(1'b0, 1'b0, '0);
            t++;
        end
        if (q.size() != 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL drain_timeout: got %0d beats outstanding required 0", q.size());
            q.delete();
        end
        repeat (3) cyc(1'b0, 1'b0, '0);
    endtask

    initial begin
        int c0;
        // Reset state
        rst = 1'b1;
        repeat (3) cyc(1'b0, 1'b0, '0);
        check("rst_tvalid", 32'(m_tvalid), 0);
        check("rst_tuser", 32'(m_tuser), 0);
        check("rst_tlast", 32'(m_tlast), 0);
        check("rst_tdata", 32'(m_tdata), 0);
        check("rst_ovf", 32'(ovf), 0);
        check("rst_line_len", 32'(line_len), 0);
        check("rst_vtg_ce", 32'(vid_vtg_ce), 0);
        rst = 1'b0;
        repeat (2) cyc(1'b0, 1'b0, '0);
        check("vtg_ce_run", 32'(vid_vtg_ce), 1);

        // Mid-frame lock: no vsync yet, nothing may come out
        line(5, 2, -1);
        line(5, 2, -1);
        check("nolock_tvalid", 32'(m_tvalid), 0);
        vsync_pulse(2);

        // Basic frame
        line(4, 2, 1);
        line(4, 2, 5);
        wait_drain();
        check("basic_line_len", 32'(line_len), 4);

        // Vsync while a pixel is held
        line(3, 0, -1);
        vsync_pulse(1);
        check("vsmid_line_len", 32'(line_len), 3);
        line(5, 2, -1);
        wait_drain();
        check("vsmid_line_len2", 32'(line_len), 5);

        // Full FIFO with concurrent read: ready returns exactly on the 17th write
        vsync_pulse(1);
        c0 = cycle;
        ready_low_until = c0 + 18;
        line(16, 1, 32'h100);
        line(4, 2, -1);
        wait_drain();
        check("fullrd_ovf", 32'(ovf), 0);
        check("fullrd_line_len", 32'(line_len), 4);

        // Overflow: 17th write with ready low is dropped, lock is lost
        vsync_pulse(1);
        c0 = cycle;
        ready_low_until = c0 + 20;
        line(16, 1, 32'h200);
        locked = 0;
        line(16, 2, -1);
        check("ovf_set", 32'(ovf), 1);
        line(5, 2, -1);
        wait_drain();
        check("ovf_sticky", 32'(ovf), 1);
        check("ovf_line_len", 32'(line_len), 16);
        vsync_pulse(1);
        line(4, 2, -1);
        wait_drain();
        check("ovf_relock_len", 32'(line_len), 4);
        check("ovf_still", 32'(ovf), 1);
        ovf_clr = 1'b1;
        cyc(1'b0, 1'b0, '0);
        ovf_clr = 1'b0;
        check("ovf_clr", 32'(ovf), 0);

        // Reset mid-line
        vsync_pulse(1);
        ready_low_until = cycle + 1000;
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, DW'($urandom));
        rst = 1'b1;
        cyc(1'b0, 1'b1, DW'($urandom));
        check("mrst_tvalid", 32'(m_tvalid), 0);
        check("mrst_tuser", 32'(m_tuser), 0);
        check("mrst_tlast", 32'(m_tlast), 0);
        check("mrst_tdata", 32'(m_tdata), 0);
        check("mrst_line_len", 32'(line_len), 0);
        check("mrst_vtg_ce", 32'(vid_vtg_ce), 0);
        rst = 1'b0;
        locked = 0;
        sof_pending = 0;
        ready_low_until = 0;
        line(4, 2, -1);
        check("mrst_nolock", 32'(m_tvalid), 0);
        vsync_pulse(1);
        line(3, 2, -1);
        wait_drain();
        check("mrst_line_len2", 32'(line_len), 3);

        // Randomized frames, bounded so the FIFO can never fill
        rand_ready = 1;
        for (int f = 0; f < 25; f++) begin
            int nl;
            if (!locked || $urandom_range(0, 3) != 0) vsync_pulse($urandom_range(1, 2));
            nl = $urandom_range(1, 3);
            for (int l = 0; l < nl; l++) line($urandom_range(1, 5), $urandom_range(1, 3), -1);
            wait_drain();
            check("rand_line_len", 32'(line_len), 32'(exp_len));
        end
        rand_ready = 0;
        check("rand_ovf", 32'(ovf), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got no end of test required finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/native_to_axis.md
NATIVE_TO_AXIS -- requirements
Module: native_to_axis

Interface
REQ-001 Parameters SHALL be:
- DATA_WID, 24, pixel width.
- PPL_WID, 12, pixel-counter width.
- FIFO_DEPTH, 16, output FIFO entries (power of 2, >=4).

REQ-002 Ports SHALL be:
- clk  in  1  the only clock; all logic on its rising edge.
- rst  in  1  reset, synchronous, active-high.
- vid_data  in  DATA_WID  native pixel data.
- vid_vsync  in  1  native vertical sync, active-high.
- vid_active  in  1  native active-video flag.
- vid_vtg_ce  out  1  clock enable back to the timing generator.
- m_tdata  out  DATA_WID  AXI-stream pixel.
- m_tuser  out  1  start of frame, first pixel of frame.
- m_tlast  out  1  end of line, last pixel of line.
- m_tvalid  out  1  AXI-stream valid.
- m_tready  in  1  AXI-stream ready.
- ovf_clr  in  1  clears the sticky overflow flag.
- ovf  out  1  sticky FIFO overflow flag.
- line_len  out  PPL_WID  pixel count of the last completed line.

Function
REQ-003 The block SHALL convert a free-running native video stream (no backpressure) into AXI4-Stream video: one beat per active pixel, tuser on the first frame pixel, tlast on the last line pixel.

REQ-004 States SHALL be WAIT_VS, ARM and RUN.
- Transitions: WAIT_VS->ARM on a vsync rising edge (vid_vsync=1 with registered previous value 0); ARM->RUN on the first cycle with vid_active=1; RUN->ARM on a vsync rising edge; any state->WAIT_VS on overflow.

REQ-005 In WAIT_VS and ARM, active pixels SHALL be discarded, except the ARM->RUN pixel, which SHALL be captured with sof=1.

REQ-006 In RUN, each active pixel SHALL be captured into a one-entry hold register {sof,data}.
- The held pixel SHALL be written to the FIFO on the next edge that captures a new pixel (tlast=0), or on the first vid_active=0 cycle (tlast=1).

REQ-007 If a vsync rising edge occurs while a pixel is held, the held pixel SHALL be written with tlast=1 on that edge.

REQ-008 sof SHALL be 1 only for the first pixel after entering RUN; all later pixels carry sof=0.

REQ-009 The FIFO SHALL store {tuser,tlast,tdata} and expose its head with a registered tvalid.
- A beat SHALL transfer when m_tvalid=1 and m_tready=1.
- m_tdata, m_tuser and m_tlast SHALL be held stable while m_tvalid=1 and m_tready=0.

REQ-010 Latency: a pixel sampled at edge E0 is written at edge E1 at the earliest and SHALL be presented on m_t* after edge E2 if the FIFO was empty.

REQ-011 A FIFO write and read in the same cycle SHALL both complete, including when the FIFO is full: the read frees the slot and the write is accepted, with no overflow.

REQ-012 A write while the FIFO is full with no concurrent read SHALL be dropped, and the following SHALL happen on that edge:
- ovf is set;
- the hold register is cleared;
- the state goes to WAIT_VS.
Beats already in the FIFO SHALL still drain normally.

REQ-013 ovf SHALL stay 1 until an edge with ovf_clr=1; if overflow and ovf_clr occur on the same edge, ovf SHALL be 1.

REQ-014 A PPL_WID-bit counter SHALL count pixels written in the current line.
- line_len SHALL load count+1 on each tlast write; the counter then resets to 0.
- The counter SHALL saturate at all-ones.

REQ-015 vid_vtg_ce SHALL be 1 in every cycle except while rst=1.

REQ-016 Frames SHALL be forwarded only from a clean start: the first beat after reset or overflow always has tuser=1.

Reset
REQ-017 With rst=1 on an edge, the following SHALL hold after that edge:
- state=WAIT_VS;
- hold register empty;
- FIFO empty;
- m_tvalid=0, m_tuser=0, m_tlast=0, m_tdata=0;
- ovf=0;
- line_len=0;
- pixel counter=0;
- vid_vtg_ce=0;
- previous-vsync register=0.

REQ-018 Reset asserted mid-frame SHALL discard all buffered pixels; no partial beat SHALL appear after rst deasserts.

Verification
REQ-019 The bench SHALL cover these directed scenarios:
- Basic frame: vsync pulse, then 2 lines of 4 active pixels (data 1..8), 2 idle cycles between lines, m_tready=1 -> beats 1..8; tuser only on 1; tlast on 4 and 8; line_len=4.
- Mid-frame lock: stimulus starts mid-frame without a vsync -> no beats until after the next vsync rising edge; the first beat has tuser=1.
- Backpressure: m_tready=0 for 20 cycles during a 16-pixel line, FIFO_DEPTH=16 -> ovf=1 and the state goes to WAIT_VS. After ready returns, the FIFO contents drain in order, the next frame starts with tuser=1, and ovf_clr clears ovf.
- Full with concurrent read: FIFO full, m_tready=1 while a write occurs -> no overflow and no lost pixel.
- Vsync mid-line: vsync rising edge while a pixel is held -> that pixel is output with tlast=1; the next active pixel has tuser=1.
- Reset mid-line: rst pulsed after 3 pixels of a line -> m_tvalid=0 after the reset edge and all outputs at reset values; output resumes only after the next vsync.
